// File: rtl/weight_skew_bank_pkg.sv
// Shared configuration for the weight skew bank: default geometry and FSM state type.
package Config;
  localparam int sys_cols       = 4;
  localparam int W_BITWIDTH     = 8;
  localparam int w_buffer_depth = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } wsb_state_t;
endpackage

// File: rtl/weight_skew_bank_col_fifo.sv
// One weight column: sync FIFO with occupancy count, registered read and a
// read-pointer snapshot that is restored after a replay burst.
module wsb_col_fifo #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 8,
  parameter int LW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic              keep,
  input  logic              snap,
  output logic              full,
  output logic              drop,
  output logic              rd_valid,
  output logic [DWIDTH-1:0] rd_data,
  output logic [LW-1:0]     count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     snap_ptr_q, snap_ptr_d;
  logic [LW-1:0]     count_q, count_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DWIDTH-1:0] rd_data_q;
  logic              pop, wr_ok, restore;

  always_comb begin
    pop     = rd_en && !keep;
    full    = (count_q == LW'(DEPTH));
    // A full column still takes a write when the same cycle pops a word.
    wr_ok   = wr_en && (!full || pop);
    drop    = wr_en && !wr_ok;
    // First idle cycle after this column's last replay read.
    restore = keep && rd_valid_q && !rd_en;

    wr_ptr_d   = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    snap_ptr_d = snap ? rd_ptr_q : snap_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (restore)    rd_ptr_d = snap_ptr_q;
    else if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

    count_d = count_q;
    if (wr_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !wr_ok) count_d = count_q - 1'b1;

    rd_valid_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      snap_ptr_q <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      snap_ptr_q <= snap_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

  // Read-first: a same-cycle write to the read slot is not seen by this read.
  always_ff @(posedge clk) begin
    if (rst)        rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_ptr_q];
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign count    = count_q;
endmodule

// File: rtl/weight_skew_bank.sv
// Weight bank feeding a systolic array: per-column FIFOs drained as a burst,
// with column i delayed i cycles to produce the diagonal skew.
module weight_skew_bank
  import Config::*;
#(
  parameter int COLS   = sys_cols,
  parameter int DWIDTH = W_BITWIDTH,
  parameter int DEPTH  = w_buffer_depth,
  parameter int LW     = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [COLS-1:0]              wr_en,
  input  logic [COLS-1:0][DWIDTH-1:0]  wr_data,
  output logic [COLS-1:0]              full,
  input  logic                         start,
  input  logic [LW-1:0]                len,
  input  logic                         replay,
  output logic                         ready,
  output logic [COLS-1:0]              o_valid,
  output logic [COLS-1:0][DWIDTH-1:0]  o_data,
  output logic                         done,
  output logic                         ovf
);
  localparam int CW = (LW > $clog2(COLS + 1)) ? LW : $clog2(COLS + 1);

  wsb_state_t state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    replay_q, replay_d;
  logic                    ovf_q, ovf_d;
  logic [COLS-1:1]         skew_q, skew_d;
  logic [COLS-1:0]         rd_en, len_ok, drop;
  logic [COLS-1:0][LW-1:0] count;
  logic                    accept, drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      replay_q <= 1'b0;
      ovf_q    <= 1'b0;
      skew_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      replay_q <= replay_d;
      ovf_q    <= ovf_d;
      skew_q   <= skew_d;
    end
  end

  // cnt_q holds the remaining cycles of the current DRAIN or FLUSH phase minus one.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    replay_d = replay_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = DRAIN;
          cnt_d    = CW'(len) - CW'(1);
          replay_d = replay;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = FLUSH;
          cnt_d   = CW'(COLS - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready  = (state_q == IDLE) && (len != '0) && (&len_ok);
    accept = start && ready;
    drain  = (state_q == DRAIN);
    done   = (state_q == DONE);
    ovf_d  = ovf_q | (|drop);
  end

  assign ovf = ovf_q;

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : gen_col
      if (gi == 0) begin : gen_head
        assign rd_en[gi] = drain;
      end else begin : gen_tail
        assign rd_en[gi]  = skew_q[gi];
        assign skew_d[gi] = rd_en[gi-1];
      end

      assign len_ok[gi] = (count[gi] >= len);

      wsb_col_fifo #(
        .DWIDTH(DWIDTH),
        .DEPTH (DEPTH),
        .LW    (LW)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en[gi]),
        .wr_data (wr_data[gi]),
        .rd_en   (rd_en[gi]),
        .keep    (replay_q),
        .snap    (accept),
        .full    (full[gi]),
        .drop    (drop[gi]),
        .rd_valid(o_valid[gi]),
        .rd_data (o_data[gi]),
        .count   (count[gi])
      );
    end
  endgenerate
endmodule

// File: tb/tb_weight_skew_bank.sv
// Bench for weight_skew_bank: directed scenarios then random traffic, every
// cycle compared against a queue-based model of the burst timing rules.
module tb_weight_skew_bank;
  localparam int COLS  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [COLS-1:0]          wr_en;
  logic [COLS-1:0][DW-1:0]  wr_data;
  logic [COLS-1:0]          full;
  logic                     start;
  logic [LW-1:0]            len;
  logic                     replay;
  logic                     ready;
  logic [COLS-1:0]          o_valid;
  logic [COLS-1:0][DW-1:0]  o_data;
  logic                     done;
  logic                     ovf;

  weight_skew_bank #(.COLS(COLS), .DWIDTH(DW), .DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .start(start), .len(len), .replay(replay), .ready(ready),
    .o_valid(o_valid), .o_data(o_data), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: each column is a queue; a burst is a timer t counted from the accept cycle.
  logic [DW-1:0] q    [COLS][$];
  logic [DW-1:0] snap [COLS][$];
  logic [DW-1:0] m_data [COLS];
  bit m_active, m_replay, m_ovf;
  int m_t, m_len;

  function automatic bit m_ready(input int l);
    if (m_active || l == 0) return 1'b0;
    for (int i = 0; i < COLS; i++) if (q[i].size() < l) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < COLS; i++) begin
      q[i].delete();
      snap[i].delete();
      m_data[i] = '0;
    end
    m_active = 0; m_replay = 0; m_ovf = 0; m_t = 0; m_len = 0;
  endtask

  task automatic step(input bit r, input logic [COLS-1:0] we,
                      input logic [COLS-1:0][DW-1:0] wd, input bit st,
                      input int l, input bit rp, input string ph);
    logic [COLS-1:0]         e_valid, e_full;
    logic [COLS-1:0][DW-1:0] e_data;
    bit popped [COLS];
    bit acc;
    @(negedge clk);
    rst = r; wr_en = we; wr_data = wd; start = st; len = l[LW-1:0]; replay = rp;
    #1;
    for (int i = 0; i < COLS; i++) begin
      e_valid[i] = m_active && (m_t >= 2 + i) && (m_t <= m_len + 1 + i);
      e_full[i]  = (q[i].size() == DEPTH);
      e_data[i]  = m_data[i];
    end
    if (chk_en) begin
      chk({ph, ":ready"}, ready, m_ready(l));
      chk({ph, ":done"}, done, m_active && (m_t == m_len + COLS + 1));
      chk({ph, ":ovf"}, ovf, m_ovf);
      chk({ph, ":full"}, full, e_full);
      chk({ph, ":o_valid"}, o_valid, e_valid);
      chk({ph, ":o_data"}, o_data, e_data);
      $display("cyc %s rst=%0b we=%b st=%0b len=%0d rp=%0b rdy=%0b v=%b d=%h done=%0b ovf=%0b",
               ph, r, we, st, l, rp, ready, o_valid, o_data, done, ovf);
    end
    if (r) begin
      m_reset();
    end else begin
      acc = st && m_ready(l);
      if (acc) for (int i = 0; i < COLS; i++) snap[i] = q[i];
      for (int i = 0; i < COLS; i++) begin
        popped[i] = 0;
        if (m_active && (m_t >= 1 + i) && (m_t <= m_len + i)) begin
          if (m_replay) m_data[i] = snap[i][m_t - 1 - i];
          else begin
            m_data[i] = q[i].pop_front();
            popped[i] = 1;
          end
        end
      end
      for (int i = 0; i < COLS; i++)
        if (we[i]) begin
          if (q[i].size() < DEPTH || popped[i]) q[i].push_back(wd[i]);
          else m_ovf = 1;
        end
      if (m_active) begin
        if (m_t == m_len + COLS + 1) m_active = 0;
        else m_t++;
      end else if (acc) begin
        m_active = 1; m_t = 1; m_len = l; m_replay = rp;
      end
    end
  endtask

  function automatic logic [COLS-1:0][DW-1:0] rnd_data();
    logic [COLS-1:0][DW-1:0] d;
    for (int i = 0; i < COLS; i++) d[i] = DW'($urandom);
    return d;
  endfunction

  task automatic idle(input int n, input int l, input string ph);
    for (int k = 0; k < n; k++) step(0, '0, '0, 0, l, 0, ph);
  endtask

  task automatic fill(input logic [COLS-1:0] mask, input int n, input string ph);
    for (int k = 0; k < n; k++) step(0, mask, rnd_data(), 0, 1, 0, ph);
  endtask

  initial begin
    m_reset();
    step(1, '0, '0, 0, 1, 0, "rst");
    step(1, '0, '0, 0, 1, 0, "rst");
    chk_en = 1;
    idle(2, 1, "reset_state");

    // 8 words per column, drained once.
    fill('1, 8, "w8");
    step(0, '0, '0, 1, 8, 0, "b8");
    idle(16, 1, "b8");

    // Replay burst twice over 4 words, then pop them.
    fill('1, 4, "w4");
    step(0, '0, '0, 1, 4, 1, "rp1");
    idle(10, 4, "rp1");
    step(0, '0, '0, 1, 4, 1, "rp2");
    idle(10, 4, "rp2");
    step(0, '0, '0, 1, 4, 0, "pop4");
    idle(10, 1, "pop4");

    // Column 2 one word short: start ignored until it is topped up.
    fill('1, 3, "short");
    fill(4'b1011, 1, "short");
    step(0, '0, '0, 1, 4, 0, "short_st");
    idle(4, 4, "short");
    step(0, 4'b0100, rnd_data(), 0, 4, 0, "top2");
    idle(2, 4, "top_rdy");
    step(0, '0, '0, 1, 4, 0, "short_b");
    idle(10, 1, "short_b");

    // Overfill column 0.
    fill(4'b0001, DEPTH + 1, "ovf");
    idle(3, 1, "ovf_hold");
    step(1, '0, '0, 0, 1, 0, "rst2");
    idle(1, 1, "post_rst2");

    // Reset in the middle of a burst.
    fill('1, 8, "w8b");
    step(0, '0, '0, 1, 8, 0, "abort");
    idle(4, 8, "abort");
    step(1, '0, '0, 0, 8, 0, "abort_rst");
    idle(16, 8, "post_abort");

    // Full column 1 written only on its pop cycles.
    fill('1, DEPTH, "wfull");
    step(0, '0, '0, 1, 8, 0, "wpop");
    step(0, '0, '0, 0, 1, 0, "wpop");
    for (int k = 0; k < 8; k++) step(0, 4'b0010, rnd_data(), 0, 1, 0, "wpop");
    idle(6, 1, "wpop");
    step(1, '0, '0, 0, 1, 0, "rst3");

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [COLS-1:0] we;
      for (int i = 0; i < COLS; i++) we[i] = ($urandom_range(0, 9) < 4);
      step(($urandom_range(0, 399) == 0), we, rnd_data(), ($urandom_range(0, 3) == 0),
           $urandom_range(0, DEPTH), $urandom_range(0, 1) == 1, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
